snn_synapse_axil_slave: RTL and testbench
=========================================

# snn_synapse_axil_slave

AXI4-Lite slave that terminates the SYNAPSES port of the SNN processor and stores synaptic weights in an on-chip dual-port RAM. Host software and the block-design master BFM write and read weights over AXI4-Lite. The neuron core reads the same weights through a dedicated read-only port. The block sits directly downstream of the SYNAPSES AXI master and directly upstream of the core's weight fetch.

## Interface
- `ADDR_WIDTH`, 12: AXI byte-address width.
- `DATA_WIDTH`, 32: data width. Fixed at 32; any other value is a fatal elaboration error.
- `DEPTH`, 1024: number of weight words. Must be a power of two and ≤ 2^(ADDR_WIDTH-2).
- `ACLK` in 1: the single clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `S_AXI_AWADDR` in ADDR_WIDTH; `S_AXI_AWPROT` in 3 (ignored); `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in ADDR_WIDTH; `S_AXI_ARPROT` in 3 (ignored); `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.
- `core_rd_en` in 1: core weight-fetch request.
- `core_rd_addr` in log2(DEPTH): weight index requested by the core.
- `core_rd_data` out 32: returned weight.
- `core_rd_valid` out 1: `core_rd_data` is valid this cycle.

## Operation
- Word index = `ADDR[log2(DEPTH)+1:2]`. Address bits [1:0] are ignored.
- Write FSM states: W_IDLE → W_WRITE → W_RESP → W_IDLE.
  - In W_IDLE, AW and W are accepted independently, in either order or in the same cycle.
  - `AWREADY` is high while no AW is latched; `WREADY` is high while no W is latched.
  - Once both are latched, go to W_WRITE: one RAM port-A write, byte-enabled by `WSTRB`.
  - W_RESP holds `BVALID` until `BREADY`.
- Read FSM states: R_IDLE → R_RAM → R_DATA → R_IDLE.
  - `ARREADY` is high only in R_IDLE.
  - R_RAM issues the port-A read.
  - R_DATA holds `RVALID`, `RDATA` and `RRESP` stable until `RREADY`.
- Port-A arbitration: if W_WRITE and R_RAM coincide, the write wins and R_RAM retries next cycle. A read that follows a write to the same word returns the new data.
- Core port is port B and is read-only. It is never stalled by AXI traffic.
- Port-B collision with a same-cycle port-A write to the same word: read-first, so the core gets the old data.
- `BRESP`/`RRESP` = OKAY (2'b00), except where the Configuration section says otherwise.

## Timing
- Reset values: all AXI outputs 0, `core_rd_valid` 0, `core_rd_data` 0, both FSMs idle. `AWREADY`, `WREADY` and `ARREADY` rise in the first cycle after `ARESETN` deasserts.
- Write: last of AW/W handshake in cycle N → RAM write in N+1 → `BVALID` high in N+2.
- Read: AR handshake in N → `RVALID` in N+2, or N+3 if port A loses arbitration.
- Core: `core_rd_en` in N → `core_rd_valid` and `core_rd_data` in N+1. Back-to-back reads give one result per cycle.
- No new AW, W or AR is accepted until the outstanding B or R has been handshaken. The block handles at most one write and one read in flight.
- `ARESETN` asserted mid-transaction: the transaction is abandoned, handshake outputs drop asynchronously, and RAM contents are undefined-but-retained (the RAM is not reset).

## Configuration
- `SNN_SYN_ADDR_CHECK_EN` defined:
  - Any address with nonzero bits above `log2(DEPTH)+1` is out of range.
  - Out-of-range write: dropped, `BRESP` = SLVERR (2'b10).
  - Out-of-range read: `RDATA` = 0, `RRESP` = SLVERR. Latency is unchanged.
- Not defined: upper address bits are ignored, the address aliases modulo DEPTH, and the response is always OKAY.

## Structure
- Package `snn_syn_pkg` holds:
  - the write and read state enums;
  - `RESP_OKAY` and `RESP_SLVERR`;
  - the `SYN_DATA_W` = 32 constant.
- Sub-module `snn_syn_ram`: true dual-port RAM with a byte-enabled read-first port A, a read-only port B, and 1-cycle read latency on both ports. It infers as BRAM.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read them back → read data 0x1–0x4, all responses OKAY.
- Write 0xAABBCCDD, then write 0x11223344 with `WSTRB`=4'b0101 to the same word → readback 0xAA22CC44.
- W presented 3 cycles before AW; `BREADY` held low for 5 cycles → `BVALID` stays high and stable, and exactly one write lands.
- Write 0x55 to word 7 while `core_rd_en` with `core_rd_addr`=7 in the same cycle → core gets the old value; a core read the next cycle gets 0x55.
- AR and a completing write collide on port A → `RVALID` one cycle later than normal, with correct data.
- With `SNN_SYN_ADDR_CHECK_EN`, write to byte address 0x1000 when DEPTH=512 → `BRESP`=2'b10 and word 0 is unchanged. Without the macro, the same write lands in word 0 with OKAY.

Source files
------------

// File: rtl/snn_syn_pkg.sv
// Shared types and constants for the SNN synapse-weight AXI4-Lite slave.
package snn_syn_pkg;

  localparam int unsigned SYN_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WWrite,
    WResp
  } w_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RRam,
    RData
  } r_state_e;

endpackage

// File: rtl/snn_syn_ram.sv
// Weight store: byte-enabled read-first port A, read-only port B, 1-cycle read latency.
// No reset on the array or read registers so it maps onto block RAM.
module snn_syn_ram
  import snn_syn_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic                    clk_i,
  input  logic [AddrW-1:0]        a_addr_i,
  input  logic [SYN_DATA_W/8-1:0] a_we_i,
  input  logic [SYN_DATA_W-1:0]   a_wdata_i,
  input  logic                    a_re_i,
  output logic [SYN_DATA_W-1:0]   a_rdata_o,
  input  logic                    b_re_i,
  input  logic [AddrW-1:0]        b_addr_i,
  output logic [SYN_DATA_W-1:0]   b_rdata_o
);

  logic [SYN_DATA_W-1:0] mem_q [Depth];
  logic [SYN_DATA_W-1:0] a_rdata_q;
  logic [SYN_DATA_W-1:0] b_rdata_q;

  // Non-blocking reads of mem_q give read-first behaviour on a same-cycle write.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SYN_DATA_W / 8; i++) begin
      if (a_we_i[i]) begin
        mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
    end
    if (a_re_i) begin
      a_rdata_q <= mem_q[a_addr_i];
    end
    if (b_re_i) begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/snn_synapse_axil_slave.sv
// AXI4-Lite slave holding SNN synaptic weights, with a never-stalled core read port.
// Define SNN_SYN_ADDR_CHECK_EN to reject out-of-range addresses with SLVERR.
module snn_synapse_axil_slave
  import snn_syn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [SYN_DATA_W-1:0]    S_AXI_WDATA,
  input  logic [SYN_DATA_W/8-1:0]  S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [SYN_DATA_W-1:0]    S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  input  logic                     core_rd_en,
  input  logic [$clog2(DEPTH)-1:0] core_rd_addr,
  output logic [SYN_DATA_W-1:0]    core_rd_data,
  output logic                     core_rd_valid
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  if (DATA_WIDTH != SYN_DATA_W) begin : g_bad_data_width
    $fatal(1, "snn_synapse_axil_slave: DATA_WIDTH must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (1 << (ADDR_WIDTH - 2)))
  begin : g_bad_depth
    $fatal(1, "snn_synapse_axil_slave: DEPTH must be a power of two <= 2^(ADDR_WIDTH-2)");
  end

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic                    init_q;
  logic                    aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [SYN_DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    core_vld_q;
  logic                    w_oor, r_oor;
  logic [3:0]              ram_we;
  logic                    ram_re;
  logic [IdxW-1:0]         ram_a_addr;
  logic [SYN_DATA_W-1:0]   ram_a_rdata, ram_b_rdata;
  logic                    unused_bits;

`ifdef SNN_SYN_ADDR_CHECK_EN
  assign w_oor = (awaddr_q >> (IdxW + 2)) != '0;
  assign r_oor = (araddr_q >> (IdxW + 2)) != '0;
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q, araddr_q};

  // init_q keeps every ready low until the first clock after reset release.
  assign S_AXI_AWREADY = init_q && (w_state_q == WIdle) && !aw_vld_q;
  assign S_AXI_WREADY  = init_q && (w_state_q == WIdle) && !w_vld_q;
  assign S_AXI_ARREADY = init_q && (r_state_q == RIdle);
  assign S_AXI_BVALID  = (w_state_q == WResp);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (r_state_q == RData);
  assign S_AXI_RRESP   = (S_AXI_RVALID && r_oor) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RDATA   = (S_AXI_RVALID && !r_oor) ? ram_a_rdata : '0;
  assign core_rd_valid = core_vld_q;
  assign core_rd_data  = core_vld_q ? ram_b_rdata : '0;

  // Port A: a pending write always beats a pending read.
  assign ram_re     = (r_state_q == RRam) && (w_state_q != WWrite);
  assign ram_a_addr = (w_state_q == WWrite) ? awaddr_q[IdxW+1:2] : araddr_q[IdxW+1:2];

  always_comb begin
    w_state_d = w_state_q;
    aw_vld_d  = aw_vld_q;
    w_vld_d   = w_vld_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    ram_we    = '0;
    unique case (w_state_q)
      WIdle: begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          aw_vld_d = 1'b1;
          awaddr_d = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
          w_vld_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if (aw_vld_d && w_vld_d) begin
          w_state_d = WWrite;
        end
      end
      WWrite: begin
        ram_we    = w_oor ? 4'b0000 : wstrb_q;
        bresp_d   = w_oor ? RESP_SLVERR : RESP_OKAY;
        aw_vld_d  = 1'b0;
        w_vld_d   = 1'b0;
        w_state_d = WResp;
      end
      WResp: begin
        if (S_AXI_BREADY) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    unique case (r_state_q)
      RIdle: begin
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          araddr_d  = S_AXI_ARADDR;
          r_state_d = RRam;
        end
      end
      RRam: begin
        if (ram_re) begin
          r_state_d = RData;
        end
      end
      RData: begin
        if (S_AXI_RREADY) begin
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q  <= WIdle;
      r_state_q  <= RIdle;
      init_q     <= 1'b0;
      aw_vld_q   <= 1'b0;
      w_vld_q    <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      core_vld_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      init_q     <= 1'b1;
      aw_vld_q   <= aw_vld_d;
      w_vld_q    <= w_vld_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      core_vld_q <= core_rd_en;
    end
  end

  snn_syn_ram #(
    .Depth (DEPTH)
  ) u_ram (
    .clk_i     (ACLK),
    .a_addr_i  (ram_a_addr),
    .a_we_i    (ram_we),
    .a_wdata_i (wdata_q),
    .a_re_i    (ram_re),
    .a_rdata_o (ram_a_rdata),
    .b_re_i    (core_rd_en),
    .b_addr_i  (core_rd_addr),
    .b_rdata_o (ram_b_rdata)
  );

endmodule

// File: tb/tb_snn_synapse_axil_slave.sv
// Self-checking bench for snn_synapse_axil_slave (DEPTH=512, 13-bit addresses).
// Expectations follow SNN_SYN_ADDR_CHECK_EN when it is defined for the build.
module tb_snn_synapse_axil_slave;

  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned IW    = 9;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic          core_en;
  logic [IW-1:0] core_addr;
  logic [31:0]   core_data;
  logic          core_valid;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] mem_m [DEPTH];

  snn_synapse_axil_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (s_awaddr),
    .S_AXI_AWPROT  (3'b000),
    .S_AXI_AWVALID (s_awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (s_wdata),
    .S_AXI_WSTRB   (s_wstrb),
    .S_AXI_WVALID  (s_wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (s_bready),
    .S_AXI_ARADDR  (s_araddr),
    .S_AXI_ARPROT  (3'b000),
    .S_AXI_ARVALID (s_arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (s_rready),
    .core_rd_en    (core_en),
    .core_rd_addr  (core_addr),
    .core_rd_data  (core_data),
    .core_rd_valid (core_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, cycles=%0d required<50000", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // Drives one write from a negedge; lat = cycles from last AW/W handshake to BVALID.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output logic [1:0] resp, output int lat,
                           output bit stable, output bit to);
    int  n, hs;
    bit  aw_done, w_done;
    aw_done = 0; w_done = 0; n = 0; hs = 0; stable = 1; to = 0; lat = -1; resp = 2'bxx;
    while (!(aw_done && w_done) && n < 100) begin
      if (!aw_done && n >= aw_dly) begin s_awvalid = 1; s_awaddr = addr; end
      if (!w_done && n >= w_dly) begin s_wvalid = 1; s_wdata = data; s_wstrb = strb; end
      if (s_awvalid && awready) begin aw_done = 1; hs = cyc; end
      if (s_wvalid && wready) begin w_done = 1; hs = cyc; end
      @(negedge clk); n++;
      if (aw_done) s_awvalid = 0;
      if (w_done) s_wvalid = 0;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) begin to = 1; return; end
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) begin to = 1; return; end
    lat  = cyc - hs;
    resp = bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      if (!bvalid || bresp !== resp) stable = 0;
    end
    s_bready = 1;
    @(negedge clk);
    s_bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_dly, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit stable,
                          output bit to);
    int n, hs;
    n = 0; stable = 1; to = 0; lat = -1; data = 'x; resp = 2'bxx;
    s_arvalid = 1; s_araddr = addr;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    hs = cyc;
    @(negedge clk);
    s_arvalid = 0;
    if (n >= 50) begin to = 1; return; end
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) begin to = 1; return; end
    lat = cyc - hs; data = rdata; resp = rresp;
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      if (!rvalid || rdata !== data || rresp !== resp) stable = 0;
    end
    s_rready = 1;
    @(negedge clk);
    s_rready = 0;
  endtask

  task automatic test_reset;
    logic [47:0] outs;
    repeat (3) @(negedge clk);
    outs = {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata, core_valid,
            core_data[4:0]};
    n_cmp++;
    if (outs !== '0 || core_data !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h / core_data %h, required all 0", outs, core_data);
    end
    rst_n = 1;
    #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_err++; $display("FAIL reset_release_ready_early: got %b required 000",
                        {awready, wready, arready});
    end
    @(negedge clk);
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_err++; $display("FAIL reset_ready_rise: got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_reset_mid;
    int n;
    s_awvalid = 1; s_awaddr = 13'h40; s_wvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    n = 0;
    while (!bvalid && n < 10) begin @(negedge clk); n++; end
    n_cmp++;
    if (bvalid !== 1'b1) begin n_err++; $display("FAIL mid_reset_bvalid: got %b required 1", bvalid); end
    rst_n = 0;
    #1;
    n_cmp++;
    if ({bvalid, awready, wready, arready} !== 4'b0000) begin
      n_err++; $display("FAIL mid_reset_async_drop: got %b required 0000",
                        {bvalid, awready, wready, arready});
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    bit          st, to;
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, r, lat, st, to);
      model_write(i, 32'(i + 1), 4'hF);
      n_cmp++;
      if (to || r !== 2'b00 || lat != 2) begin
        n_err++; $display("FAIL basic_write%0d: resp %b lat %0d to %0d, required 00 lat 2", i, r, lat, to);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(i * 4), i, d, r, lat, st, to);
      n_cmp++;
      if (to || d !== 32'(i + 1) || r !== 2'b00 || lat != 2 || !st) begin
        n_err++; $display("FAIL basic_read%0d: data %h resp %b lat %0d stable %0d, required %h 00 2 1",
                          i, d, r, lat, st, i + 1);
      end
    end
  endtask

  task automatic test_strobe;
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    bit          st, to;
    axi_write(13'h14, 32'hAABB_CCDD, 4'hF, 0, 0, 0, r, lat, st, to);
    axi_write(13'h14, 32'h1122_3344, 4'b0101, 0, 0, 0, r, lat, st, to);
    model_write(5, 32'hAABB_CCDD, 4'hF);
    model_write(5, 32'h1122_3344, 4'b0101);
    axi_read(13'h14, 0, d, r, lat, st, to);
    n_cmp++;
    if (to || d !== 32'hAA22_CC44 || r !== 2'b00) begin
      n_err++; $display("FAIL strobe_merge: data %h resp %b, required aa22cc44 00", d, r);
    end
  endtask

  task automatic test_w_first;
    logic [1:0]  r;
    logic [31:0] d, v;
    int          lat;
    bit          st, to;
    v = $urandom;
    axi_write(13'h24, v, 4'hF, 3, 0, 5, r, lat, st, to);
    model_write(9, v, 4'hF);
    n_cmp++;
    if (to || !st || lat != 2 || r !== 2'b00) begin
      n_err++; $display("FAIL w_first_bhold: stable %0d lat %0d resp %b to %0d, required 1 2 00 0",
                        st, lat, r, to);
    end
    n_cmp++;
    if (bvalid !== 1'b0) begin n_err++; $display("FAIL w_first_single_b: bvalid %b required 0", bvalid); end
    axi_read(13'h24, 0, d, r, lat, st, to);
    n_cmp++;
    if (to || d !== mem_m[9]) begin
      n_err++; $display("FAIL w_first_readback: data %h required %h", d, mem_m[9]);
    end
  endtask

  task automatic test_core_collision;
    logic [1:0]  r;
    logic [31:0] old;
    int          lat;
    bit          st, to;
    old = $urandom;
    axi_write(13'h1C, old, 4'hF, 0, 0, 0, r, lat, st, to);
    model_write(7, old, 4'hF);
    s_awvalid = 1; s_awaddr = 13'h1C; s_wvalid = 1; s_wdata = 32'h55; s_wstrb = 4'hF;
    s_bready = 1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    core_en = 1; core_addr = 9'd7;
    @(negedge clk);
    n_cmp++;
    if (core_valid !== 1'b1 || core_data !== old) begin
      n_err++; $display("FAIL core_read_first: valid %b data %h, required 1 %h", core_valid, core_data, old);
    end
    @(negedge clk);
    n_cmp++;
    if (core_valid !== 1'b1 || core_data !== 32'h55) begin
      n_err++; $display("FAIL core_after_write: valid %b data %h, required 1 00000055", core_valid, core_data);
    end
    model_write(7, 32'h55, 4'hF);
    core_en = 0; s_bready = 0;
    @(negedge clk);
  endtask

  task automatic test_port_a_collision;
    logic [31:0] v, rd;
    logic [1:0]  rr;
    int          hs, b_at, r_at;
    v = $urandom;
    s_awvalid = 1; s_awaddr = 13'h28; s_wvalid = 1; s_wdata = v; s_wstrb = 4'hF;
    s_arvalid = 1; s_araddr = 13'h28; s_bready = 1; s_rready = 1;
    hs = cyc;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_err++; $display("FAIL collide_ready: got %b required 111", {awready, wready, arready});
    end
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    b_at = -1; r_at = -1; rd = 'x; rr = 'x;
    for (int i = 0; i < 8; i++) begin
      if (bvalid && b_at < 0) b_at = cyc - hs;
      if (rvalid && r_at < 0) begin r_at = cyc - hs; rd = rdata; rr = rresp; end
      @(negedge clk);
    end
    s_bready = 0; s_rready = 0;
    model_write(10, v, 4'hF);
    n_cmp++;
    if (b_at != 2 || r_at != 3) begin
      n_err++; $display("FAIL collide_latency: b %0d r %0d, required b 2 r 3", b_at, r_at);
    end
    n_cmp++;
    if (rd !== v || rr !== 2'b00) begin
      n_err++; $display("FAIL collide_data: data %h resp %b, required %h 00", rd, rr, v);
    end
  endtask

  task automatic test_addr_check;
    logic [1:0]  r, rexp;
    logic [31:0] d, dexp;
    int          lat;
    bit          st, to;
    axi_write(13'h0, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r, lat, st, to);
    model_write(0, 32'hCAFE_F00D, 4'hF);
    axi_write(13'h1000, 32'hDEAD_0001, 4'hF, 0, 0, 0, r, lat, st, to);
`ifdef SNN_SYN_ADDR_CHECK_EN
    rexp = 2'b10;
`else
    rexp = 2'b00;
    model_write(0, 32'hDEAD_0001, 4'hF);
`endif
    n_cmp++;
    if (to || r !== rexp || lat != 2) begin
      n_err++; $display("FAIL oor_write_resp: resp %b lat %0d, required %b 2", r, lat, rexp);
    end
    axi_read(13'h0, 0, d, r, lat, st, to);
    n_cmp++;
    if (to || d !== mem_m[0] || r !== 2'b00) begin
      n_err++; $display("FAIL oor_word0: data %h resp %b, required %h 00", d, r, mem_m[0]);
    end
    axi_read(13'h1000, 1, d, r, lat, st, to);
`ifdef SNN_SYN_ADDR_CHECK_EN
    dexp = 32'h0;
`else
    dexp = mem_m[0];
`endif
    n_cmp++;
    if (to || d !== dexp || r !== rexp || lat != 2 || !st) begin
      n_err++; $display("FAIL oor_read: data %h resp %b lat %0d, required %h %b 2", d, r, lat, dexp, rexp);
    end
  endtask

  task automatic test_random;
    logic [1:0]  r;
    logic [31:0] d, v;
    logic [3:0]  s;
    int          lat, idx;
    bit          st, to;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      axi_write(AW'(i * 4), v, 4'hF, 0, 0, 0, r, lat, st, to);
      model_write(i, v, 4'hF);
    end
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; s = 4'($urandom);
        axi_write(AW'(idx * 4 + $urandom_range(0, 3)), v, s, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), r, lat, st, to);
        model_write(idx, v, s);
        n_cmp++;
        if (to || r !== 2'b00 || lat != 2 || !st) begin
          n_err++; $display("FAIL rand_write%0d: resp %b lat %0d stable %0d, required 00 2 1", k, r, lat, st);
        end
      end else begin
        axi_read(AW'(idx * 4 + $urandom_range(0, 3)), $urandom_range(0, 3), d, r, lat, st, to);
        n_cmp++;
        if (to || d !== mem_m[idx] || r !== 2'b00 || lat != 2 || !st) begin
          n_err++; $display("FAIL rand_read%0d: word %0d data %h lat %0d, required %h lat 2",
                            k, idx, d, lat, mem_m[idx]);
        end
      end
    end
  endtask

  task automatic test_core_back_to_back;
    bit       prev_en;
    int       prev_idx;
    prev_en = 0; prev_idx = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin
        n_cmp++;
        if (core_valid !== prev_en || (prev_en && core_data !== mem_m[prev_idx])) begin
          n_err++; $display("FAIL core_b2b%0d: valid %b data %h, required %b %h",
                            k, core_valid, core_data, prev_en, mem_m[prev_idx]);
        end
      end
      prev_en  = (k < 20) || ($urandom_range(0, 1) == 1);
      prev_idx = $urandom_range(0, 15);
      core_en = prev_en; core_addr = IW'(prev_idx);
      @(negedge clk);
    end
    core_en = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    s_awaddr = '0; s_araddr = '0; s_awvalid = 0; s_wvalid = 0; s_bready = 0;
    s_arvalid = 0; s_rready = 0; s_wdata = '0; s_wstrb = '0; core_en = 0; core_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    test_reset;
    test_reset_mid;
    test_basic;
    test_strobe;
    test_w_first;
    test_core_collision;
    test_port_a_collision;
    test_addr_check;
    test_random;
    test_core_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
